// File: rtl/asp_pkg.sv
`default_nettype none
//============================================================================
// Module      : asp_pkg
// Description : Definitions shared between the ASP network peer and the ASP
//               side: default payload/tag widths and the transmit FSM state
//               encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//============================================================================
package asp_pkg;

  // Default frame geometry: a frame is {payload, tag}.
  localparam int c_data_size = 16;
  localparam int c_tag_size  = 4;

  // Transmit FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } tx_state_e;

endpackage : asp_pkg
`default_nettype wire

// File: rtl/asp_peer_timer.sv
`default_nettype none
//============================================================================
// Module      : asp_peer_timer
// Description : Acknowledge-wait timer. Clearable up-counter that flags the
//               cycle in which the count of enabled cycles reaches
//               timeout_cycles.
// Ports       : clk     - clock, rising edge
//               reset   - asynchronous, active-low reset
//               clear   - synchronous clear of the count (priority over enable)
//               enable  - count this cycle
//               expired - high in the enabled cycle that completes the
//                         timeout_cycles-th enabled cycle since clear
// Revision    : 1.0 - initial release
//============================================================================
module asp_peer_timer #(
  parameter int timeout_cycles = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int c_cnt_w = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  // The count holds the number of enabled cycles already completed, so the
  // timeout_cycles-th enabled cycle is the one that sees timeout_cycles-1.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(timeout_cycles - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + c_cnt_one;
    end
  end

  assign expired = enable && (r_count == c_cnt_last);

endmodule : asp_peer_timer
`default_nettype wire

// File: rtl/asp_net_peer.sv
`default_nettype none
//============================================================================
// Module      : asp_net_peer
// Description : Stop-and-wait peer between a local application and the ASP
//               network. Receive path checks sequence tags, delivers
//               in-order payloads and returns ACKs; transmit path sends one
//               application payload at a time and retransmits on timeout.
// Ports       : clk, reset              - clock / async active-low reset
//               rx_ready_in, rx_ack_in  - incoming frame valid / is-ACK
//               rx_data_tag_in          - incoming {data, tag}
//               tx_ready_out, tx_ack_out- outgoing frame valid / is-ACK
//               tx_data_tag_out         - outgoing {data, tag}, 0 when idle
//               app_valid_in, app_data_in, app_ready_out - local send request
//               app_data_valid_out, app_data_out         - delivered payload
//               tag_error_out           - out-of-sequence data frame pulse
//               timeout_error_out       - frame abandoned pulse
// Revision    : 1.0 - initial release
//============================================================================
module asp_net_peer
  import asp_pkg::*;
#(
  parameter int data_size      = c_data_size,
  parameter int tag_size       = c_tag_size,
  parameter int timeout_cycles = 16,
  parameter int max_retries    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_ready_in,
  input  logic                          rx_ack_in,
  input  logic [data_size+tag_size-1:0] rx_data_tag_in,
  output logic                          tx_ready_out,
  output logic                          tx_ack_out,
  output logic [data_size+tag_size-1:0] tx_data_tag_out,
  input  logic                          app_valid_in,
  input  logic [data_size-1:0]          app_data_in,
  output logic                          app_ready_out,
  output logic                          app_data_valid_out,
  output logic [data_size-1:0]          app_data_out,
  output logic                          tag_error_out,
  output logic                          timeout_error_out
);

  localparam int c_retry_w = (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  localparam logic [tag_size-1:0]  c_tag_one   = tag_size'(1);
  localparam logic [c_retry_w-1:0] c_retry_one = c_retry_w'(1);
  localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(max_retries);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  tx_state_e              r_state;
  tx_state_e              w_state_next;
  logic [tag_size-1:0]    r_rx_exp_tag;
  logic [tag_size-1:0]    r_tx_tag;
  logic [c_retry_w-1:0]   r_retries;
  logic [data_size-1:0]   r_frame_data;

  // --------------------------------------------------------------------------
  // Receive path classification
  // --------------------------------------------------------------------------
  logic [tag_size-1:0]    w_rx_tag;
  logic [data_size-1:0]   w_rx_payload;
  logic [tag_size-1:0]    w_rx_prev_tag;
  logic                   w_rx_data;
  logic                   w_rx_new;
  logic                   w_rx_dup;
  logic                   w_rx_bad;
  logic                   w_ack_emit;
  logic                   w_ack_match;

  assign w_rx_tag      = rx_data_tag_in[tag_size-1:0];
  assign w_rx_payload  = rx_data_tag_in[tag_size +: data_size];
  assign w_rx_prev_tag = r_rx_exp_tag - c_tag_one;
  assign w_rx_data     = rx_ready_in && !rx_ack_in;
  assign w_rx_new      = w_rx_data && (w_rx_tag == r_rx_exp_tag);
  // A repeat of the last delivered frame means our ACK was lost: re-ACK it.
  assign w_rx_dup      = w_rx_data && (w_rx_tag == w_rx_prev_tag);
  assign w_rx_bad      = w_rx_data && !w_rx_new && !w_rx_dup;
  assign w_ack_emit    = w_rx_new || w_rx_dup;
  assign w_ack_match   = rx_ready_in && rx_ack_in && (w_rx_tag == r_tx_tag);

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_load_frame;
  logic w_timer_clear;
  logic w_timer_en;
  logic w_timer_expired;
  logic w_tx_tag_inc;
  logic w_retry_inc;
  logic w_retry_clr;
  logic w_timeout_pulse;

  // Gated by reset so the port reads 0 while reset is held.
  assign app_ready_out = (r_state == ST_IDLE) && reset;

  asp_peer_timer #(
    .timeout_cycles (timeout_cycles)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_timer_clear),
    .enable  (w_timer_en),
    .expired (w_timer_expired)
  );

  always_comb begin
    w_state_next    = r_state;
    w_accept        = 1'b0;
    w_load_frame    = 1'b0;
    w_timer_clear   = 1'b0;
    w_timer_en      = 1'b0;
    w_tx_tag_inc    = 1'b0;
    w_retry_inc     = 1'b0;
    w_retry_clr     = 1'b0;
    w_timeout_pulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (app_valid_in && app_ready_out) begin
          w_accept     = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        // An outgoing ACK owns the tx bus this cycle; the data frame waits
        // one more cycle and the timer is not started yet.
        if (!w_ack_emit) begin
          w_load_frame  = 1'b1;
          w_timer_clear = 1'b1;
          w_state_next  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        w_timer_en = 1'b1;
        // ACK is checked first so it wins over a same-cycle timeout.
        if (w_ack_match) begin
          w_tx_tag_inc = 1'b1;
          w_retry_clr  = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_timer_expired) begin
          if (r_retries < c_retry_max) begin
            w_retry_inc  = 1'b1;
            w_state_next = ST_SEND;
          end else begin
            w_timeout_pulse = 1'b1;
            w_tx_tag_inc    = 1'b1;
            w_retry_clr     = 1'b1;
            w_state_next    = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_rx_exp_tag <= '0;
      r_tx_tag     <= '0;
      r_retries    <= '0;
      r_frame_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_rx_new) begin
        r_rx_exp_tag <= r_rx_exp_tag + c_tag_one;
      end
      if (w_accept) begin
        r_frame_data <= app_data_in;
      end
      if (w_tx_tag_inc) begin
        r_tx_tag <= r_tx_tag + c_tag_one;
      end
      if (w_retry_clr) begin
        r_retries <= '0;
      end else if (w_retry_inc) begin
        r_retries <= r_retries + c_retry_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ready_out       <= 1'b0;
      tx_ack_out         <= 1'b0;
      tx_data_tag_out    <= '0;
      app_data_valid_out <= 1'b0;
      app_data_out       <= '0;
      tag_error_out      <= 1'b0;
      timeout_error_out  <= 1'b0;
    end else begin
      if (w_ack_emit) begin
        tx_ready_out    <= 1'b1;
        tx_ack_out      <= 1'b1;
        tx_data_tag_out <= rx_data_tag_in;
      end else if (w_load_frame) begin
        tx_ready_out    <= 1'b1;
        tx_ack_out      <= 1'b0;
        tx_data_tag_out <= {r_frame_data, r_tx_tag};
      end else begin
        tx_ready_out    <= 1'b0;
        tx_ack_out      <= 1'b0;
        tx_data_tag_out <= '0;
      end
      app_data_valid_out <= w_rx_new;
      if (w_rx_new) begin
        app_data_out <= w_rx_payload;
      end
      tag_error_out     <= w_rx_bad;
      timeout_error_out <= w_timeout_pulse;
    end
  end

endmodule : asp_net_peer
`default_nettype wire

// File: tb/tb_asp_net_peer.sv
`default_nettype none
//============================================================================
// Module      : tb_asp_net_peer
// Description : Self-checking bench for asp_net_peer with a behavioural
//               protocol model and directed scenarios.
// Ports       : none
// Revision    : 1.0 - initial release
//============================================================================
module tb_asp_net_peer;

  localparam int T = 16;
  localparam int R = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_ready_in = 1'b0;
  logic        rx_ack_in = 1'b0;
  logic [19:0] rx_data_tag_in = '0;
  logic        tx_ready_out;
  logic        tx_ack_out;
  logic [19:0] tx_data_tag_out;
  logic        app_valid_in = 1'b0;
  logic [15:0] app_data_in = '0;
  logic        app_ready_out;
  logic        app_data_valid_out;
  logic [15:0] app_data_out;
  logic        tag_error_out;
  logic        timeout_error_out;

  int n_vec  = 0;
  int n_fail = 0;

  asp_net_peer #(
    .data_size      (16),
    .tag_size       (4),
    .timeout_cycles (T),
    .max_retries    (R)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .rx_ready_in        (rx_ready_in),
    .rx_ack_in          (rx_ack_in),
    .rx_data_tag_in     (rx_data_tag_in),
    .tx_ready_out       (tx_ready_out),
    .tx_ack_out         (tx_ack_out),
    .tx_data_tag_out    (tx_data_tag_out),
    .app_valid_in       (app_valid_in),
    .app_data_in        (app_data_in),
    .app_ready_out      (app_ready_out),
    .app_data_valid_out (app_data_valid_out),
    .app_data_out       (app_data_out),
    .tag_error_out      (tag_error_out),
    .timeout_error_out  (timeout_error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: protocol-level view (expected tag, outstanding frame,
  // cycles waited, attempts made), producing next-cycle output expectations.
  // --------------------------------------------------------------------------
  int          m_rx_exp   = 0;
  int          m_tx_tag   = 0;
  int          m_mode     = 0;   // 0: no frame, 1: frame wants the bus, 2: awaiting ACK
  int          m_waited   = 0;
  int          m_attempts = 0;
  int          m_tg       = 0;
  bit          m_ack_now  = 0;
  logic [15:0] m_pend     = '0;
  logic [15:0] m_app_data = '0;
  bit          m_valid = 0, m_tagerr = 0, m_to = 0, m_txr = 0, m_txa = 0;
  logic [19:0] m_txdt = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rx_exp = 0; m_tx_tag = 0; m_mode = 0; m_waited = 0; m_attempts = 0;
      m_pend = '0; m_app_data = '0;
      m_valid = 0; m_tagerr = 0; m_to = 0; m_txr = 0; m_txa = 0; m_txdt = '0;
    end else begin
      m_valid = 0; m_tagerr = 0; m_to = 0; m_txr = 0; m_txa = 0; m_txdt = '0;
      m_ack_now = 0;
      m_tg = int'(rx_data_tag_in[3:0]);
      if (rx_ready_in && !rx_ack_in) begin
        if (m_tg == m_rx_exp) begin
          m_valid = 1; m_app_data = rx_data_tag_in[19:4]; m_ack_now = 1;
          m_rx_exp = (m_rx_exp + 1) % 16;
        end else if (m_tg == (m_rx_exp + 15) % 16) begin
          m_ack_now = 1;
        end else begin
          m_tagerr = 1;
        end
      end
      if (m_ack_now) begin
        m_txr = 1; m_txa = 1; m_txdt = rx_data_tag_in;
      end
      case (m_mode)
        0: if (app_valid_in) begin m_pend = app_data_in; m_mode = 1; end
        1: if (!m_ack_now) begin
             m_txr = 1; m_txdt = {m_pend, 4'(m_tx_tag)}; m_mode = 2; m_waited = 0;
           end
        default: begin
          m_waited++;
          if (rx_ready_in && rx_ack_in && m_tg == m_tx_tag) begin
            m_mode = 0; m_tx_tag = (m_tx_tag + 1) % 16; m_attempts = 0;
          end else if (m_waited == T) begin
            if (m_attempts < R) begin
              m_attempts++; m_mode = 1;
            end else begin
              m_to = 1; m_tx_tag = (m_tx_tag + 1) % 16; m_attempts = 0; m_mode = 0;
            end
          end
        end
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("cmp_tx_ready",  32'(tx_ready_out),       32'(m_txr));
    check("cmp_tx_ack",    32'(tx_ack_out),         32'(m_txa));
    check("cmp_tx_data",   32'(tx_data_tag_out),    32'(m_txdt));
    check("cmp_app_ready", 32'(app_ready_out),      32'((m_mode == 0) && reset));
    check("cmp_app_valid", 32'(app_data_valid_out), 32'(m_valid));
    check("cmp_app_data",  32'(app_data_out),       32'(m_app_data));
    check("cmp_tag_err",   32'(tag_error_out),      32'(m_tagerr));
    check("cmp_timeout",   32'(timeout_error_out),  32'(m_to));
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_in();
    rx_ready_in = 0; rx_ack_in = 0; rx_data_tag_in = '0; app_valid_in = 0;
  endtask

  task automatic drive_rx(input logic ack, input logic [15:0] d, input logic [3:0] t);
    rx_ready_in = 1; rx_ack_in = ack; rx_data_tag_in = {d, t};
  endtask

  initial begin
    int frame_at[$];
    int to_at;
    int n_to;
    clear_in();
    reset = 0;
    repeat (3) step();
    check("rst_tx_ready", 32'(tx_ready_out), 0);
    check("rst_app_ready", 32'(app_ready_out), 0);
    #2 reset = 1;
    step();
    check("app_ready_after_rst", 32'(app_ready_out), 1);

    // In-order delivery with ACK
    drive_rx(0, 16'hABBD, 4'h0); step(); clear_in();
    check("deliver_valid", 32'(app_data_valid_out), 1);
    check("deliver_data", 32'(app_data_out), 32'hABBD);
    check("deliver_ack", 32'(tx_ack_out), 1);
    check("deliver_ack_frame", 32'(tx_data_tag_out), 32'hABBD0);

    // Out-of-sequence tag
    drive_rx(0, 16'hBEEF, 4'hA); step(); clear_in();
    check("bad_tag_err", 32'(tag_error_out), 1);
    check("bad_tag_no_ack", 32'(tx_ready_out), 0);

    // Duplicate of last frame: re-ACK only
    drive_rx(0, 16'hABBD, 4'h0); step(); clear_in();
    check("dup_ack", 32'(tx_ack_out), 1);
    check("dup_ack_frame", 32'(tx_data_tag_out), 32'hABBD0);
    check("dup_no_deliver", 32'(app_data_valid_out), 0);

    // Application send, ACK 5 cycles later
    app_valid_in = 1; app_data_in = 16'hC129; step(); clear_in();
    check("send_busy", 32'(app_ready_out), 0);
    step();
    check("send_frame_valid", 32'(tx_ready_out), 1);
    check("send_frame_kind", 32'(tx_ack_out), 0);
    check("send_frame", 32'(tx_data_tag_out), 32'hC1290);
    step();
    check("send_one_cycle", 32'(tx_ready_out), 0);
    repeat (3) step();
    drive_rx(1, 16'h0000, 4'h0); step(); clear_in();
    check("ack_to_idle", 32'(app_ready_out), 1);

    // Reset while awaiting ACK: frame dropped, no timeout pulse
    app_valid_in = 1; app_data_in = 16'hD00D; step(); clear_in();
    step();
    check("second_frame_tag1", 32'(tx_data_tag_out), 32'hD00D1);
    repeat (5) step();
    #3 reset = 0;
    step();
    check("midreset_app_ready", 32'(app_ready_out), 0);
    #2 reset = 1;
    n_to = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (timeout_error_out || tx_ready_out) n_to++;
    end
    check("midreset_silent", 32'(n_to), 0);

    // No ACK: 4 transmissions, then abandon
    app_valid_in = 1; app_data_in = 16'h5A5A; step(); clear_in();
    n_to = 0; to_at = -1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (tx_ready_out && !tx_ack_out) begin
        frame_at.push_back(c);
        check("retx_frame", 32'(tx_data_tag_out), 32'h5A5A0);
      end
      if (timeout_error_out) begin n_to++; to_at = c; end
    end
    check("retx_count", 32'(frame_at.size()), 4);
    for (int i = 1; i < frame_at.size(); i++)
      check("retx_spacing", 32'(frame_at[i] - frame_at[i-1]), 32'(T + 1));
    check("timeout_pulses", 32'(n_to), 1);
    if (frame_at.size() > 0)
      check("timeout_delay", 32'(to_at - frame_at[frame_at.size()-1]), 32'(T));

    // Tag advanced after abandon; wrong-tag ACK ignored
    app_valid_in = 1; app_data_in = 16'h6B6B; step(); clear_in();
    step();
    check("post_timeout_tag1", 32'(tx_data_tag_out), 32'h6B6B1);
    drive_rx(1, 16'h0000, 4'h5); step(); clear_in();
    check("wrong_ack_ignored", 32'(app_ready_out), 0);
    drive_rx(1, 16'h0000, 4'h1); step(); clear_in();
    check("right_ack_idle", 32'(app_ready_out), 1);

    // Contention: ACK before data frame; then ACK coinciding with timeout
    app_valid_in = 1; app_data_in = 16'h7777; step(); clear_in();
    drive_rx(0, 16'h1111, 4'h0); step(); clear_in();
    check("contend_ack_first", 32'(tx_ack_out), 1);
    check("contend_ack_frame", 32'(tx_data_tag_out), 32'h11110);
    step();
    check("contend_data_next", 32'(tx_data_tag_out), 32'h77772);
    check("contend_data_kind", 32'(tx_ack_out), 0);
    repeat (15) step();
    drive_rx(1, 16'h0000, 4'h2); step(); clear_in();
    check("ack_beats_timeout", 32'(app_ready_out), 1);
    step();
    check("no_retx_after_ack", 32'(tx_ready_out), 0);

    // 16 in-order frames and wrap to tag 0
    #2 reset = 0; step(); #2 reset = 1; step();
    for (int i = 0; i < 17; i++) begin
      drive_rx(0, 16'(16'h1000 + i), 4'(i % 16)); step(); clear_in();
      check("wrap_deliver", 32'(app_data_valid_out), 1);
      check("wrap_data", 32'(app_data_out), 32'(16'h1000 + i));
    end
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_asp_net_peer
`default_nettype wire
